// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: per-requester byte handshake plus UART FIFO push signals
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic [DATA_WIDTH-1:0]         tx_byte;
  logic                          tx_push;
  logic                          tx_full;
  modport master (output req_valid, req_data, req_last, tx_full, input req_ready, tx_byte, tx_push);
  modport slave  (input req_valid, req_data, req_last, tx_full, output req_ready, tx_byte, tx_push);
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, message-granular sharing of one UART TX FIFO; UART_ARB_TAG_EN prefixes each grant with an ASCII id tag
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int MAX_BURST    = 64,
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  uart_tx_arbiter_if.slave           bus,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
  state_t state, state_nx;
  logic [IW-1:0] ptr, pick, idx;
  logic [BW-1:0] burst_cnt;
  logic [TW-1:0] idle_cnt;
  logic any_req, cur_valid, cur_last, accept, release_now, tag_push, tag_pend;
  logic [DATA_WIDTH-1:0] cur_data, tag_byte;
  assign cur_valid = bus.req_valid[grant_id];
  assign cur_last  = bus.req_last[grant_id];
  assign cur_data  = DATA_WIDTH'(bus.req_data >> (DATA_WIDTH * int'(grant_id)));
  assign tag_byte  = DATA_WIDTH'(8'h30 + 8'(grant_id));
  assign busy      = state != IDLE;
  // Pick the first valid requester at or after the round-robin pointer; scanning backwards lets the nearest one win
  always_comb begin
    pick = ptr;
    any_req = 1'b0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr) + k) % NUM_REQ);
      if (bus.req_valid[idx]) begin
        pick = idx;
        any_req = 1'b1;
      end
    end
  end
`ifdef UART_ARB_TAG_EN
  // Arm the id tag on every new grant and drop it once pushed or when the grant ends
  always_ff @(posedge clk or negedge reset)
    if (!reset) tag_pend <= 1'b0;
    else if (state == IDLE && any_req) tag_pend <= 1'b1;
    else if (tag_push || state != GRANT) tag_pend <= 1'b0;
  assign tag_push = state == GRANT && tag_pend && !bus.tx_full;
`else
  assign tag_pend = 1'b0;
  assign tag_push = 1'b0;
`endif
  // Next state: a grant ends on a last byte, a full burst, or the granted requester going quiet too long
  always_comb begin
    accept = state == GRANT && !bus.tx_full && !tag_pend && cur_valid;
    release_now = (accept && (cur_last || burst_cnt == BW'(MAX_BURST - 1))) ||
                  (!cur_valid && idle_cnt == TW'(IDLE_TIMEOUT - 1));
    state_nx = state == IDLE ? (any_req ? GRANT : IDLE) :
               state == RELEASE ? IDLE : (release_now ? RELEASE : GRANT);
  end
  assign bus.req_ready = (state == GRANT && !bus.tx_full && !tag_pend) ? NUM_REQ'(1) << grant_id : '0;
  assign bus.tx_push   = accept || tag_push;
  assign bus.tx_byte   = tag_push ? tag_byte : accept ? cur_data : '0;
  // State register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  // Grant holder, round-robin pointer and per-grant burst/idle counters
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      grant_id  <= '0;
      ptr       <= '0;
      burst_cnt <= '0;
      idle_cnt  <= '0;
    end else begin
      if (state == IDLE && any_req) grant_id <= pick;
      if (state == RELEASE) ptr <= grant_id == IW'(NUM_REQ - 1) ? '0 : grant_id + IW'(1);
      burst_cnt <= state == GRANT ? burst_cnt + BW'(accept) : '0;
      idle_cnt  <= (state == GRANT && !cur_valid) ? idle_cnt + TW'(1) : '0;
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized checks of uart_tx_arbiter against a message-level model
module tb_uart_tx_arbiter;
  localparam int N = 4, W = 8, MB = 4, IT = 16;
`ifdef UART_ARB_TAG_EN
  localparam bit TAG = 1'b1;
`else
  localparam bit TAG = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0;
  logic [1:0] grant_id;
  logic busy;
  uart_tx_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(W)) bus ();
  uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .MAX_BURST(MB), .IDLE_TIMEOUT(IT)) dut (
    .clk(clk), .reset(reset), .bus(bus), .grant_id(grant_id), .busy(busy));
  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  logic [8:0] drv_q[N][$];
  logic [8:0] exp_q[N][$];
  int gap[N];
  logic [7:0] push_log[$];
  logic [7:0] want[$];
  int grant_log[$];
  int phase = 0, rr = 0, exp_gid = 0, cnt = 0, idle = 0, full_cnt = 0;
  bit tag_pend = 1'b0, new_grant = 1'b0, rand_full = 1'b0, rand_gap = 1'b0;
  logic [N-1:0] s_valid, s_rdy;
  logic s_push, s_full;
  logic [7:0] s_byte;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic put(input int id, input logic [7:0] b, input bit last);
    drv_q[id].push_back({last, b});
    exp_q[id].push_back({last, b});
  endtask

  task automatic drive();
    bit v;
    for (int i = 0; i < N; i++) begin
      v = gap[i] == 0 && drv_q[i].size() > 0;
      if (gap[i] > 0) gap[i]--;
      bus.req_valid[i] = v;
      bus.req_last[i] = v ? drv_q[i][0][8] : 1'b0;
      bus.req_data[i*W +: W] = v ? drv_q[i][0][7:0] : 8'h00;
    end
    bus.tx_full = full_cnt > 0 || (rand_full && $urandom_range(0, 3) == 0);
    if (full_cnt > 0) full_cnt--;
  endtask

  task automatic model();
    logic [8:0] e;
    if (phase == 0) begin
      chk("idle_busy", busy, 0);
      chk("idle_push", s_push, 0);
      if (|s_valid) begin
        for (int k = N - 1; k >= 0; k--) if (s_valid[(rr + k) % N]) exp_gid = (rr + k) % N;
        phase = 1; cnt = 0; idle = 0; tag_pend = TAG; new_grant = 1'b1;
      end
    end else if (phase == 1) begin
      chk("grant_busy", busy, 1);
      chk("grant_id", grant_id, exp_gid);
      if (new_grant) begin grant_log.push_back(exp_gid); new_grant = 1'b0; end
      chk("ready", s_rdy, (!s_full && !tag_pend) ? (1 << exp_gid) : 0);
      chk("push", s_push, !s_full && (tag_pend || s_valid[exp_gid]));
      idle = s_valid[exp_gid] ? 0 : idle + 1;
      if (s_push) begin
        push_log.push_back(s_byte);
        if (tag_pend) begin
          chk("tag", s_byte, 8'h30 + exp_gid);
          tag_pend = 1'b0;
        end else begin
          chk("byte_avail", exp_q[exp_gid].size() > 0, 1);
          if (exp_q[exp_gid].size() > 0) begin
            e = exp_q[exp_gid].pop_front();
            chk("byte", s_byte, e[7:0]);
            cnt++;
            if (e[8] || cnt == MB) phase = 2;
          end
        end
      end
      if (idle == IT) phase = 2;
    end else begin
      chk("rel_busy", busy, 1);
      chk("rel_push", s_push, 0);
      chk("rel_ready", s_rdy, 0);
      rr = (exp_gid + 1) % N;
      phase = 0;
    end
  endtask

  task automatic cycle();
    #1;
    s_valid = bus.req_valid; s_rdy = bus.req_ready; s_push = bus.tx_push;
    s_byte = bus.tx_byte; s_full = bus.tx_full;
    model();
    @(negedge clk);
    for (int i = 0; i < N; i++)
      if (s_valid[i] && s_rdy[i]) begin
        void'(drv_q[i].pop_front());
        gap[i] = rand_gap ? int'($urandom_range(0, 3)) : 0;
      end
    drive();
  endtask

  task automatic run(input int limit);
    int n = 0;
    while (n < limit && !(phase == 0 && drv_q[0].size() + drv_q[1].size() + drv_q[2].size() + drv_q[3].size() == 0)) begin
      cycle();
      n++;
    end
    chk("drain", n < limit, 1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_push", bus.tx_push, 0);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_gid", grant_id, 0);
    @(negedge clk);
    reset = 1'b1; phase = 0; rr = 0;
    drive();
  endtask

  task automatic chk_log(input string tag);
    chk({tag, "_len"}, push_log.size(), want.size());
    for (int k = 0; k < want.size() && k < push_log.size(); k++) chk(tag, push_log[k], want[k]);
    push_log.delete(); want.delete(); grant_log.delete();
  endtask

  initial begin
    int ord[5] = '{0, 1, 2, 3, 0};
    int id, len;
    bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0; bus.tx_full = 1'b0;
    for (int i = 0; i < N; i++) begin gap[i] = 0; put(i, 8'h10 + 8'(i), 1'b1); end
    put(0, 8'h20, 1'b1);
    drive();
    repeat (3) begin
      @(negedge clk);
      drive();
      #1;
      chk("rst_hold_busy", busy, 0);
      chk("rst_hold_push", bus.tx_push, 0);
      chk("rst_hold_ready", bus.req_ready, 0);
      chk("rst_hold_gid", grant_id, 0);
    end
    @(negedge clk);
    reset = 1'b1;
    drive();
    run(200);
    chk("rr_count", grant_log.size(), 5);
    for (int k = 0; k < 5 && k < grant_log.size(); k++) chk("rr_order", grant_log[k], ord[k]);
    push_log.delete(); grant_log.delete();

    put(2, 8'h48, 1'b0); put(2, 8'h69, 1'b1);
    run(100);
    chk("msg_gid", grant_id, 2);
    if (TAG) want.push_back(8'h32);
    want.push_back(8'h48); want.push_back(8'h69);
    chk_log("msg");

    put(1, 8'hA0, 1'b0); put(1, 8'hA1, 1'b0); put(1, 8'hA2, 1'b1);
    for (int n = 0; n < 50 && push_log.size() < (TAG ? 2 : 1); n++) cycle();
    chk("bp_first", push_log.size(), TAG ? 2 : 1);
    full_cnt = 5;
    run(100);
    if (TAG) want.push_back(8'h31);
    want.push_back(8'hA0); want.push_back(8'hA1); want.push_back(8'hA2);
    chk_log("bp");

    put(2, 8'hD0, 1'b0); put(2, 8'hD1, 1'b0); put(2, 8'hD2, 1'b1);
    for (int n = 0; n < 50 && push_log.size() < (TAG ? 2 : 1); n++) cycle();
    do_reset();
    run(100);
    push_log.delete(); grant_log.delete();

    do_reset();
    for (int k = 0; k < 6; k++) put(0, 8'hB0 + 8'(k), 1'b0);
    put(3, 8'hC0, 1'b1);
    run(300);
    chk("lim_grants", grant_log.size(), 3);
    for (int k = 0; k < 3 && k < grant_log.size(); k++) chk("lim_order", grant_log[k], k == 1 ? 3 : 0);
    for (int k = 0; k < 7; k++) begin
      if (TAG && (k == 0 || k == 4 || k == 5)) want.push_back(k == 4 ? 8'h33 : 8'h30);
      want.push_back(k < 4 ? 8'hB0 + 8'(k) : k == 4 ? 8'hC0 : 8'hB0 + 8'(k - 1));
    end
    chk_log("lim");

    put(1, 8'h41, 1'b1);
    run(100);
    if (TAG) want.push_back(8'h31);
    want.push_back(8'h41);
    chk_log("tag");

    rand_full = 1'b1; rand_gap = 1'b1;
    repeat (4) begin
      repeat (10) begin
        id = int'($urandom_range(0, N - 1));
        len = int'($urandom_range(1, 6));
        for (int k = 0; k < len; k++)
          put(id, 8'($urandom), k == len - 1 && $urandom_range(0, 4) != 0);
      end
      run(4000);
    end
    for (int i = 0; i < N; i++) chk("rand_left", exp_q[i].size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
